// File: rtl/acceso_pkg.sv
// Shared types and constants for the parking-gate access controller.
// Holds the state enumeration, BCD limits and the default PIN.
package acceso_pkg;

  typedef enum logic [2:0] {
    ESPERA,
    ESPERA_CLAVE,
    ABIERTO,
    CERRANDO,
    ALARMA_PIN,
    BLOQUEO
  } estado_t;

  localparam int unsigned BCD_MAX = 9;
  localparam logic [15:0] CLAVE_DEFECTO = 16'h1194;

  function automatic logic es_digito_bcd(input logic [3:0] nibble);
    return (32'(nibble) <= BCD_MAX);
  endfunction

endpackage

// File: rtl/temporizador_compuerta.sv
// Load/decrement down-counter for the gate open and close intervals.
// o_fin is high while the count is zero; the count never goes below zero.
module temporizador_compuerta #(
  parameter int ANCHO = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_carga,
  input  logic [ANCHO-1:0] i_valor,
  input  logic             i_decrementa,
  output logic             o_fin
);

  logic [ANCHO-1:0] r_cuenta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cuenta <= '0;
    end else if (i_carga) begin
      r_cuenta <= i_valor;
    end else if (i_decrementa && (r_cuenta != '0)) begin
      r_cuenta <= r_cuenta - ANCHO'(1);
    end
  end

  assign o_fin = (r_cuenta == '0);

endmodule

// File: rtl/controlador_acceso_param.sv
// Parking-gate access controller: BCD PIN check, attempt limit, gate timing, tailgate alarm.
// Optional admitted-vehicle counter enabled by defining CONTADOR_VEHICULOS_EN.
//
// state        | meaning
// ESPERA       | idle, waiting for a vehicle at the gate
// ESPERA_CLAVE | vehicle present, waiting for a PIN strobe
// ABIERTO      | gate opening/open, waiting for passage or timeout
// CERRANDO     | gate closing for T_CIERRE cycles
// ALARMA_PIN   | too many wrong PINs, waits for the operator button
// BLOQUEO      | tailgate detected, only a correct PIN releases it
module controlador_acceso_param
  import acceso_pkg::*;
#(
  parameter int                   DIGITOS        = 4,
  parameter logic [4*DIGITOS-1:0] CLAVE_CORRECTA = (4*DIGITOS)'(CLAVE_DEFECTO),
  parameter int                   MAX_INTENTOS   = 3,
  parameter int                   T_APERTURA     = 16,
  parameter int                   T_CIERRE       = 4,
  parameter int                   CNT_W          = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                llegado_vehiculo,
  input  logic [4*DIGITOS-1:0]                clave_ingresada,
  input  logic                                clave_valida,
  input  logic                                paso_vehiculo,
  input  logic                                boton_reset,
  output logic                                abriendo_compuerta,
  output logic                                cerrando_compuerta,
  output logic                                alarm_pin_incorrecto,
  output logic                                alarm_bloqueo,
  output logic [$clog2(MAX_INTENTOS+1)-1:0]   intentos
`ifdef CONTADOR_VEHICULOS_EN
  ,
  output logic [CNT_W-1:0]                    vehiculos_ingresados
`endif
);

  localparam int INT_W = $clog2(MAX_INTENTOS + 1);
  localparam int T_MAX = (T_APERTURA > T_CIERRE) ? T_APERTURA : T_CIERRE;
  localparam int TW    = $clog2(T_MAX + 1);

  // Timer counts T-1 down to 0 so the state lasts exactly T cycles on timeout.
  localparam logic [TW-1:0]    CARGA_APERTURA = TW'(T_APERTURA - 1);
  localparam logic [TW-1:0]    CARGA_CIERRE   = TW'(T_CIERRE - 1);
  localparam logic [INT_W-1:0] INT_LIMITE     = INT_W'(MAX_INTENTOS);

  estado_t          r_estado;
  logic [INT_W-1:0] r_intentos;
  logic             r_ac, r_cp, r_ai, r_ab;

  estado_t          w_estado_sig;
  logic [INT_W-1:0] w_intentos_sig;
  logic [INT_W-1:0] w_intentos_inc;
  logic             w_pin_ok;
  logic             w_colado;
  logic             w_paso_normal;
  logic             w_carga;
  logic [TW-1:0]    w_valor;
  logic             w_dec;
  logic             w_fin;

  function automatic logic pin_correcto(input logic [4*DIGITOS-1:0] clave);
    logic ok;
    ok = (clave == CLAVE_CORRECTA);
    for (int d = 0; d < DIGITOS; d++) begin
      if (!es_digito_bcd(clave[4*d +: 4])) ok = 1'b0;
    end
    return ok;
  endfunction

  assign w_pin_ok       = pin_correcto(clave_ingresada);
  assign w_colado       = paso_vehiculo && llegado_vehiculo;
  assign w_paso_normal  = paso_vehiculo && !llegado_vehiculo;
  assign w_intentos_inc = (r_intentos == INT_LIMITE) ? r_intentos : r_intentos + INT_W'(1);

  temporizador_compuerta #(
    .ANCHO(TW)
  ) u_temporizador (
    .clk         (clk),
    .reset       (reset),
    .i_carga     (w_carga),
    .i_valor     (w_valor),
    .i_decrementa(w_dec),
    .o_fin       (w_fin)
  );

  always_comb begin
    w_estado_sig   = r_estado;
    w_intentos_sig = r_intentos;
    w_carga        = 1'b0;
    w_valor        = '0;
    w_dec          = 1'b0;
    case (r_estado)
      ESPERA: begin
        if (llegado_vehiculo) w_estado_sig = ESPERA_CLAVE;
      end
      ESPERA_CLAVE: begin
        if (clave_valida) begin
          if (w_pin_ok) begin
            w_intentos_sig = '0;
            w_estado_sig   = ABIERTO;
            w_carga        = 1'b1;
            w_valor        = CARGA_APERTURA;
          end else begin
            w_intentos_sig = w_intentos_inc;
            if (w_intentos_inc == INT_LIMITE) w_estado_sig = ALARMA_PIN;
          end
        end else if (!llegado_vehiculo) begin
          w_estado_sig = ESPERA;
        end
      end
      ABIERTO: begin
        if (w_colado) begin
          w_estado_sig = BLOQUEO;
        end else if (w_paso_normal || w_fin) begin
          w_estado_sig = CERRANDO;
          w_carga      = 1'b1;
          w_valor      = CARGA_CIERRE;
        end else begin
          w_dec = 1'b1;
        end
      end
      CERRANDO: begin
        if (w_colado) begin
          w_estado_sig = BLOQUEO;
        end else if (w_fin) begin
          w_estado_sig = ESPERA;
        end else begin
          w_dec = 1'b1;
        end
      end
      ALARMA_PIN: begin
        if (boton_reset) begin
          w_intentos_sig = '0;
          w_estado_sig   = ESPERA;
        end
      end
      BLOQUEO: begin
        if (clave_valida && w_pin_ok) begin
          w_intentos_sig = '0;
          w_estado_sig   = ESPERA;
        end
      end
      default: w_estado_sig = ESPERA;
    endcase
  end

  // Outputs are registered from the next state so they track the state with no extra lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado   <= ESPERA;
      r_intentos <= '0;
      r_ac       <= 1'b0;
      r_cp       <= 1'b0;
      r_ai       <= 1'b0;
      r_ab       <= 1'b0;
    end else begin
      r_estado   <= w_estado_sig;
      r_intentos <= w_intentos_sig;
      r_ac       <= (w_estado_sig == ABIERTO);
      r_cp       <= (w_estado_sig == CERRANDO);
      r_ai       <= (w_estado_sig == ALARMA_PIN);
      r_ab       <= (w_estado_sig == BLOQUEO);
    end
  end

  assign abriendo_compuerta   = r_ac;
  assign cerrando_compuerta   = r_cp;
  assign alarm_pin_incorrecto = r_ai;
  assign alarm_bloqueo        = r_ab;
  assign intentos             = r_intentos;

`ifdef CONTADOR_VEHICULOS_EN
  logic [CNT_W-1:0] r_vehiculos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vehiculos <= '0;
    end else if ((r_estado == ABIERTO) && w_paso_normal) begin
      r_vehiculos <= r_vehiculos + CNT_W'(1);
    end
  end

  assign vehiculos_ingresados = r_vehiculos;
`endif

endmodule
